// File: rtl/ysyx_22050710_axi4_rd_arbiter.sv
// Two-master AXI4 read-channel arbiter (m0 = IFU, m1 = LSU) onto one SRAM slave.
// Round-robin on ties, one burst in flight, registered grant (one cycle latency).
module ysyx_22050710_axi4_rd_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  i_aclk,
    input  logic                  i_rst,
    // master 0 (IFU)
    input  logic [3:0]            i_m0_arid,
    input  logic [ADDR_WIDTH-1:0] i_m0_araddr,
    input  logic [7:0]            i_m0_arlen,
    input  logic [2:0]            i_m0_arsize,
    input  logic [1:0]            i_m0_arburst,
    input  logic                  i_m0_arvalid,
    output logic                  o_m0_arready,
    output logic [3:0]            o_m0_rid,
    output logic [DATA_WIDTH-1:0] o_m0_rdata,
    output logic [1:0]            o_m0_rresp,
    output logic                  o_m0_rlast,
    output logic                  o_m0_rvalid,
    input  logic                  i_m0_rready,
    // master 1 (LSU)
    input  logic [3:0]            i_m1_arid,
    input  logic [ADDR_WIDTH-1:0] i_m1_araddr,
    input  logic [7:0]            i_m1_arlen,
    input  logic [2:0]            i_m1_arsize,
    input  logic [1:0]            i_m1_arburst,
    input  logic                  i_m1_arvalid,
    output logic                  o_m1_arready,
    output logic [3:0]            o_m1_rid,
    output logic [DATA_WIDTH-1:0] o_m1_rdata,
    output logic [1:0]            o_m1_rresp,
    output logic                  o_m1_rlast,
    output logic                  o_m1_rvalid,
    input  logic                  i_m1_rready,
    // shared slave
    output logic [3:0]            o_s_arid,
    output logic [ADDR_WIDTH-1:0] o_s_araddr,
    output logic [7:0]            o_s_arlen,
    output logic [2:0]            o_s_arsize,
    output logic [1:0]            o_s_arburst,
    output logic                  o_s_arvalid,
    input  logic                  i_s_arready,
    input  logic [3:0]            i_s_rid,
    input  logic [DATA_WIDTH-1:0] i_s_rdata,
    input  logic [1:0]            i_s_rresp,
    input  logic                  i_s_rlast,
    input  logic                  i_s_rvalid,
    output logic                  o_s_rready,
    output logic                  o_owner
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_e;

    state_e     state_q, state_d;
    logic       owner_q, owner_d;
    logic       last_owner_q, last_owner_d;
    logic [7:0] len_q, len_d;
    logic [7:0] beat_q, beat_d;

    logic [3:0]            own_arid;
    logic [ADDR_WIDTH-1:0] own_araddr;
    logic [7:0]            own_arlen;
    logic [2:0]            own_arsize;
    logic [1:0]            own_arburst;
    logic                  own_arvalid;
    logic                  own_rready;
    logic                  ar_hs;
    logic                  r_hs;
    logic                  burst_end;

    assign own_arid    = owner_q ? i_m1_arid    : i_m0_arid;
    assign own_araddr  = owner_q ? i_m1_araddr  : i_m0_araddr;
    assign own_arlen   = owner_q ? i_m1_arlen   : i_m0_arlen;
    assign own_arsize  = owner_q ? i_m1_arsize  : i_m0_arsize;
    assign own_arburst = owner_q ? i_m1_arburst : i_m0_arburst;
    assign own_arvalid = owner_q ? i_m1_arvalid : i_m0_arvalid;
    assign own_rready  = owner_q ? i_m1_rready  : i_m0_rready;

    assign ar_hs     = (state_q == S_ADDR) && own_arvalid && i_s_arready;
    assign r_hs      = (state_q == S_DATA) && i_s_rvalid && own_rready;
    // A slave that never raises rlast is still cut off after arlen+1 beats.
    assign burst_end = i_s_rlast || (beat_q == len_q);

    assign o_owner = owner_q;

    always_comb begin
        // NOTE: every next-state and output gets a default first so no branch can infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        len_d        = len_q;
        beat_d       = beat_q;
        o_m0_arready = 1'b0;
        o_m1_arready = 1'b0;
        o_m0_rid     = '0;
        o_m0_rdata   = '0;
        o_m0_rresp   = '0;
        o_m0_rlast   = 1'b0;
        o_m0_rvalid  = 1'b0;
        o_m1_rid     = '0;
        o_m1_rdata   = '0;
        o_m1_rresp   = '0;
        o_m1_rlast   = 1'b0;
        o_m1_rvalid  = 1'b0;
        o_s_arid     = '0;
        o_s_araddr   = '0;
        o_s_arlen    = '0;
        o_s_arsize   = '0;
        o_s_arburst  = '0;
        o_s_arvalid  = 1'b0;
        o_s_rready   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_m0_arvalid || i_m1_arvalid) begin
                    owner_d = (i_m0_arvalid && i_m1_arvalid) ? ~last_owner_q : i_m1_arvalid;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                o_s_arid     = own_arid;
                o_s_araddr   = own_araddr;
                o_s_arlen    = own_arlen;
                o_s_arsize   = own_arsize;
                o_s_arburst  = own_arburst;
                o_s_arvalid  = own_arvalid;
                o_m0_arready = ~owner_q & i_s_arready;
                o_m1_arready = owner_q & i_s_arready;
                if (ar_hs) begin
                    len_d   = own_arlen;
                    beat_d  = '0;
                    state_d = S_DATA;
                end else if (!own_arvalid) begin
                    // Request withdrawn: fairness history stays untouched.
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                o_s_rready = own_rready;
                if (owner_q) begin
                    o_m1_rid    = i_s_rid;
                    o_m1_rdata  = i_s_rdata;
                    o_m1_rresp  = i_s_rresp;
                    o_m1_rvalid = i_s_rvalid;
                    o_m1_rlast  = i_s_rvalid & burst_end;
                end else begin
                    o_m0_rid    = i_s_rid;
                    o_m0_rdata  = i_s_rdata;
                    o_m0_rresp  = i_s_rresp;
                    o_m0_rvalid = i_s_rvalid;
                    o_m0_rlast  = i_s_rvalid & burst_end;
                end
                if (r_hs) begin
                    beat_d = beat_q + 8'd1;
                    if (burst_end) begin
                        state_d      = S_IDLE;
                        last_owner_d = owner_q;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: registers take their next value with non-blocking assignments only.
    always_ff @(posedge i_aclk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            len_q        <= '0;
            beat_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            len_q        <= len_d;
            beat_q       <= beat_d;
        end
    end

endmodule
